// File: rtl/dct_cnt_pkg.sv
// Shared types and constants for the DCT step counter.
package dct_cnt_pkg;

  // Counter sequencing states; StPre only reachable with DCT_CNT_PREROLL_EN.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StRun  = 2'd2,
    StHold = 2'd3
  } cnt_state_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/dct_step_counter.sv
// Start-triggered step counter for DCT datapath sequencing.
// Counts 0..term, then wraps (pulsing wrap) or saturates (pulsing done).
// Optional feature macro: DCT_CNT_PREROLL_EN adds a one-cycle pre-roll state
// in which count shows all-ones before the first real step value.
module dct_step_counter
  import dct_cnt_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEF_TERM     = 30,
  parameter int unsigned USE_DEF_TERM = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             cnt_valid,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] DefTerm = WIDTH'(DEF_TERM);

  cnt_state_e       state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;
  logic             mode_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;
  logic             wrap_q;

  logic [WIDTH-1:0] start_term;
  logic             load;
  logic             at_term;

  // Terminal value captured on start, with optional default substitution for zero.
  always_comb begin
    start_term = term_i;
    if ((USE_DEF_TERM != 0) && (term_i == '0)) begin
      start_term = DefTerm;
    end
  end

  // A new run may only begin from IDLE or HOLD; stop always wins over start.
  assign load    = start && !stop && ((state_q == StIdle) || (state_q == StHold));
  assign at_term = (count_q == term_q);

  // Sequencing FSM, counter and registered status/pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      term_q  <= '0;
      mode_q  <= MODE_WRAP;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (stop) begin
        // Count is left as-is so the last value stays observable.
        state_q <= StIdle;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (load) begin
        term_q <= start_term;
        mode_q <= mode_i;
`ifdef DCT_CNT_PREROLL_EN
        state_q <= StPre;
        count_q <= '1;
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
`else
        state_q <= StRun;
        count_q <= '0;
        busy_q  <= 1'b1;
        valid_q <= 1'b1;
`endif
      end else if (enable) begin
        case (state_q)
`ifdef DCT_CNT_PREROLL_EN
          StPre: begin
            state_q <= StRun;
            count_q <= '0;
            valid_q <= 1'b1;
          end
`endif
          StRun: begin
            if (at_term && (mode_q == MODE_SAT)) begin
              state_q <= StHold;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (at_term) begin
              count_q <= '0;
              wrap_q  <= 1'b1;
            end else begin
              count_q <= count_q + WIDTH'(1);
            end
          end
          default: begin
            // IDLE and HOLD ignore enable.
          end
        endcase
      end
    end
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign cnt_valid = valid_q;
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule
